serial_addr_responder: RTL and testbench

- Synthesizable, CLK-domain responder for the 8-bit-address / 8-bit-data serial frame driven by the master device.
- Oversamples the master's SCLK and TX lines and shifts in the address LSB-first on SCLK rising edges.
- On a match with its own address, serialises a parallel data byte LSB-first onto OUT for the master to sample. It replaces the unclocked slave model in system-level sims.

---
 rtl/serial_pkg.sv | 7 +
 rtl/sclk_edge_sync.sv | 30 +++
 rtl/serial_addr_responder.sv | 126 ++++++++++++
 tb/tb_serial_addr_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and frame geometry for the serial address/data link
package serial_pkg;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = ADDR_W + DATA_W;
    typedef enum logic [1:0] {ADDR, DATA, SKIP} state_e;
endpackage

// File: rtl/sclk_edge_sync.sv
// sclk_edge_sync: synchronises SCLK/RX into clk_i and emits aligned SCLK edge pulses
module sclk_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic rx_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic rx_s_o
);
    logic [SYNC_STAGES-1:0] sclk_q, rx_q;
    logic                   sclk_dly_q;
    // Flops reset high because the master idles SCLK high; no false edge after reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_q     <= '1;
            rx_q       <= '1;
            sclk_dly_q <= 1'b1;
        end else begin
            sclk_q     <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            rx_q       <= {rx_q[SYNC_STAGES-2:0], rx_i};
            sclk_dly_q <= sclk_q[SYNC_STAGES-1];
        end
    end
    assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_dly_q;
    assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_dly_q;
    assign rx_s_o      = rx_q[SYNC_STAGES-1];
endmodule

// File: rtl/serial_addr_responder.sv
// serial_addr_responder: receives an LSB-first address and answers a match with an LSB-first data byte
module serial_addr_responder
    import serial_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR       = 8'hA5,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter int                SYNC_STAGES    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              rx_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              out_o,
    output logic              out_en_o,
    output logic [ADDR_W-1:0] rx_addr_o,
    output logic              addr_match_o,
    output logic              xfer_done_o,
    output logic              frame_err_o,
    output logic              busy_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic rise, fall, rx_s, busy, expire, last;
    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d, rx_addr_q, rx_addr_d, addr_full;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic [TW-1:0]     to_q, to_d;
    logic              out_q, out_d, am_q, am_d, xd_q, xd_d, fe_q, fe_d;

    sclk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sclk_i     (sclk_i),
        .rx_i       (rx_i),
        .sclk_rise_o(rise),
        .sclk_fall_o(fall),
        .rx_s_o     (rx_s)
    );

    assign busy   = (state_q != ADDR) || (bit_cnt_q != 3'd0);
    assign last   = bit_cnt_q == 3'd7;
    // Expiry yields to a coincident SCLK edge
    assign expire = busy && !(rise || fall) && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        rx_addr_d = rx_addr_q;
        out_d     = out_q;
        am_d      = 1'b0;
        xd_d      = 1'b0;
        fe_d      = 1'b0;
        addr_full = addr_sh_q;
        addr_full[bit_cnt_q] = rx_s;
        to_d      = (rise || fall || !busy || expire) ? '0 : to_q + 1'b1;
        if (expire) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            out_d     = 1'b0;
            fe_d      = 1'b1;
        end else begin
            bit_cnt_d = rise ? bit_cnt_q + 3'd1 : bit_cnt_q;
            case (state_q)
                ADDR: if (rise) begin
                    addr_sh_d = addr_full;
                    if (last) begin
                        rx_addr_d = addr_full;
                        am_d      = addr_full == DEV_ADDR;
                        data_sh_d = tx_data_i;
                        state_d   = (addr_full == DEV_ADDR) ? DATA : SKIP;
                    end
                end
                DATA: begin
                    if (fall) begin
                        out_d     = data_sh_q[0];
                        data_sh_d = data_sh_q >> 1;
                    end
                    if (rise && last) begin
                        xd_d    = 1'b1;
                        out_d   = 1'b0;
                        state_d = ADDR;
                    end
                end
                default: if (rise && last) state_d = ADDR;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ADDR;
            bit_cnt_q <= 3'd0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            rx_addr_q <= '0;
            to_q      <= '0;
            out_q     <= 1'b0;
            am_q      <= 1'b0;
            xd_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            rx_addr_q <= rx_addr_d;
            to_q      <= to_d;
            out_q     <= out_d;
            am_q      <= am_d;
            xd_q      <= xd_d;
            fe_q      <= fe_d;
        end
    end

    assign out_o        = out_q;
    assign out_en_o     = state_q == DATA;
    assign rx_addr_o    = rx_addr_q;
    assign addr_match_o = am_q;
    assign xfer_done_o  = xd_q;
    assign frame_err_o  = fe_q;
    assign busy_o       = busy;
endmodule

// File: tb/tb_serial_addr_responder.sv
// tb_serial_addr_responder: directed master frames with a pulse scoreboard checked by a separate monitor
module tb_serial_addr_responder;
    localparam int T  = 256;
    localparam int PH = 8;

    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b1, rx = 1'b1;
    logic [7:0] tx_data = 8'h3C;
    logic       out, out_en, am, xd, fe, busy;
    logic [7:0] rx_addr, rx_byte = '0;
    int         cyc = 0, rise_cyc = 0, n_pass = 0, n_tot = 0;
    logic       quiet = 1'b0, loud = 1'b0;

    typedef struct {int kind; int val;} exp_t;
    exp_t sb[$];

    serial_addr_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sclk_i      (sclk),
        .rx_i        (rx),
        .tx_data_i   (tx_data),
        .out_o       (out),
        .out_en_o    (out_en),
        .rx_addr_o   (rx_addr),
        .addr_match_o(am),
        .xfer_done_o (xd),
        .frame_err_o (fe),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int k, input int v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    // kind 0 = addr match (rx_addr), 1 = xfer done (byte seen by master), 2 = frame error (cycle)
    task automatic pop_chk(input int k, input int v);
        exp_t e;
        if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_pulse kind %0d: got value %0h expected no pulse", k, v);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", k, e.kind);
            chk($sformatf("sb_val_kind%0d", k), v, e.val);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (am) pop_chk(0, int'(rx_addr));
        if (xd) pop_chk(1, int'(rx_byte));
        if (fe) pop_chk(2, cyc);
        if (quiet && (out_en || out)) loud = 1'b1;
    end

    // One SCLK period: fall (address bit driven), low phase, master samples OUT, rise, high phase
    task automatic do_bit(input int i, input logic [7:0] a, input int low);
        sclk = 1'b0;
        if (i < 8) rx = a[i];
        repeat (low) @(negedge clk);
        if (i >= 8) rx_byte[i-8] = out;
        sclk = 1'b1;
        rise_cyc = cyc;
        repeat (PH) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input bit match);
        if (match) begin
            push(0, int'(a));
            push(1, int'(d));
        end
        for (int i = 0; i < 16; i++) do_bit(i, a, PH);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_rx_addr", rx_addr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        frame(8'hA5, 8'h3C, 1'b1);
        chk("t1_out_en", out_en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_rx_addr", rx_addr, 8'hA5);

        quiet = 1'b1;
        frame(8'h5A, 8'h00, 1'b0);
        quiet = 1'b0;
        chk("t2_skip_quiet", loud, 0);
        chk("t2_rx_addr", rx_addr, 8'h5A);
        chk("t2_busy", busy, 0);
        frame(8'hA5, 8'h3C, 1'b1);

        for (int i = 0; i < 3; i++) do_bit(i, 8'hA5, PH);
        chk("t3_busy_mid", busy, 1);
        push(2, rise_cyc + T + 3);
        repeat (T + 10) @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_rx_addr_kept", rx_addr, 8'hA5);
        frame(8'hA5, 8'h3C, 1'b1);

        push(0, 8'hA5);
        for (int i = 0; i < 12; i++) do_bit(i, 8'hA5, PH);
        chk("t4_out_en_mid", out_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_out", out, 0);
        chk("t4_out_en", out_en, 0);
        chk("t4_rx_addr", rx_addr, 0);
        chk("t4_busy", busy, 0);
        repeat (PH) @(negedge clk);
        frame(8'hA5, 8'h3C, 1'b1);

        push(0, 8'hA5);
        push(1, 8'h3C);
        for (int i = 0; i < 16; i++) begin
            do_bit(i, 8'hA5, PH);
            if (i == 10) tx_data = 8'hFF;
        end
        tx_data = 8'h81;
        frame(8'hA5, 8'h81, 1'b1);

        // Rise lands exactly in the expiry cycle opened by the preceding fall
        tx_data = 8'h96;
        push(0, 8'hA5);
        push(1, 8'h96);
        for (int i = 0; i < 16; i++) do_bit(i, 8'hA5, (i == 10) ? T : PH);
        chk("t6_busy", busy, 0);
        chk("t6_out_en", out_en, 0);

        repeat (20) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
